// File: rtl/rvskid_pkg.sv
// Shared types and constants for the rvskid_buf skid buffer.
package rvskid_pkg;

  localparam int unsigned RVSKID_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } rvskid_state_t;

  function automatic logic [1:0] state_count(input rvskid_state_t st);
    case (st)
      ST_EMPTY: return 2'd0;
      ST_ONE:   return 2'd1;
      ST_FULL:  return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rvdffe_sync.sv
// WIDTH-bit flop with load enable and synchronous active-high reset to zero.
module rvdffe_sync #(
  parameter int unsigned WIDTH = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Load on enable only; reset wins.
  always_ff @(posedge clk) begin
    if (rst)
      dout <= '0;
    else if (en)
      dout <= din;
  end

endmodule

// File: rtl/rvskid_buf.sv
// Two-entry valid/ready skid buffer with fully registered outputs.
module rvskid_buf
  import rvskid_pkg::*;
#(
  parameter int unsigned WIDTH = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  rvskid_state_t    state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [1:0]       count_q, count_d;
  logic             push, pop;
  logic             main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0] main_din, skid_dout;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Next state and payload enables.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (!push && pop) begin
            state_d = ST_EMPTY;
          end else if (push && pop) begin
            main_en = 1'b1;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d        = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign count_d  = state_count(state_d);
  assign main_din = main_from_skid ? skid_dout : in_data;

  // State register with outputs decoded from the next state so each is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (count_d < 2'(RVSKID_DEPTH));
      out_valid_q <= (count_d != 2'd0);
      count_q     <= count_d;
    end
  end

  rvdffe_sync #(.WIDTH(WIDTH)) u_main (
    .clk  (clk),
    .rst  (rst),
    .en   (main_en),
    .din  (main_din),
    .dout (out_data)
  );

  rvdffe_sync #(.WIDTH(WIDTH)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .en   (skid_en),
    .din  (in_data),
    .dout (skid_dout)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

`ifndef SYNTHESIS
  // Producer must hold a refused beat unchanged (flush lets it withdraw).
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data)));
  a_valid_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(in_valid));
`endif

endmodule

// File: tb/tb_rvskid_buf.sv
module tb_rvskid_buf;

  localparam int unsigned W = 63;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  // Reference model: a bounded FIFO of depth 2.
  logic [W-1:0] mq[$];
  bit           mdl_zero;   // out_data known to be zero since last reset
  bit           last_push;  // previous edge accepted the producer beat

  rvskid_buf #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    bit acc, pp;
    last_push = 1'b0;
    if (rst) begin
      mq.delete();
      mdl_zero = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < 2);
      pp  = (mq.size() > 0) && out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(in_data);
        mdl_zero = 1'b0;
      end
      last_push = acc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 63'h7FFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data); else pass_cnt++;
    chk_cnt++; if (count !== 2'd0) $display("FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
    tick();
    chk_cnt++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL reset_idle: got valid %b count %0d expected 0 0", out_valid, count); else pass_cnt++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      tick();
      chk_cnt++; if (out_valid !== 1'b1 || out_data !== W'(i)) $display("FAIL stream_data[%0d]: got valid %b data %h expected 1 %h", i, out_valid, out_data, W'(i)); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1 || count !== 2'd1) $display("FAIL stream_flow[%0d]: got ready %b count %0d expected 1 1", i, in_ready, count); else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
    chk_cnt++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL stream_drain: got valid %b count %0d expected 0 0", out_valid, count); else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] exp_seq [3];
    exp_seq[0] = W'(64'hA); exp_seq[1] = W'(64'hB); exp_seq[2] = W'(64'hC);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = exp_seq[0];
    tick();
    chk_cnt++; if (count !== 2'd1 || in_ready !== 1'b1) $display("FAIL bp_one: got count %0d ready %b expected 1 1", count, in_ready); else pass_cnt++;
    in_data = exp_seq[1];
    tick();
    chk_cnt++; if (count !== 2'd2 || in_ready !== 1'b0) $display("FAIL bp_full: got count %0d ready %b expected 2 0", count, in_ready); else pass_cnt++;
    in_data = exp_seq[2];
    tick();
    chk_cnt++; if (count !== 2'd2 || out_data !== exp_seq[0]) $display("FAIL bp_hold: got count %0d data %h expected 2 %h", count, out_data, exp_seq[0]); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    chk_cnt++; if (out_data !== exp_seq[1] || count !== 2'd1 || in_ready !== 1'b1) $display("FAIL bp_pop_a: got data %h count %0d ready %b expected %h 1 1", out_data, count, in_ready, exp_seq[1]); else pass_cnt++;
    tick();
    chk_cnt++; if (out_data !== exp_seq[2] || count !== 2'd1) $display("FAIL bp_pop_b: got data %h count %0d expected %h 1", out_data, count, exp_seq[2]); else pass_cnt++;
    in_valid = 1'b0;
    tick();
    chk_cnt++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL bp_empty: got valid %b count %0d expected 0 0", out_valid, count); else pass_cnt++;
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(64'h5);
    tick();
    chk_cnt++; if (out_data !== W'(64'h5) || count !== 2'd1) $display("FAIL pp_load: got data %h count %0d expected 5 1", out_data, count); else pass_cnt++;
    in_data = W'(64'h6); out_ready = 1'b1;
    tick();
    chk_cnt++; if (out_data !== W'(64'h6) || count !== 2'd1 || out_valid !== 1'b1) $display("FAIL pp_swap: got data %h count %0d valid %b expected 6 1 1", out_data, count, out_valid); else pass_cnt++;
    in_valid = 1'b0;
    tick();
    chk_cnt++; if (count !== 2'd0) $display("FAIL pp_drain: got count %0d expected 0", count); else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = W'(64'h1); tick();
    in_data = W'(64'h2); tick();
    chk_cnt++; if (count !== 2'd2) $display("FAIL fl_fill: got count %0d expected 2", count); else pass_cnt++;
    in_data = W'(64'h99); out_ready = 1'b1; flush = 1'b1;
    tick();
    chk_cnt++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL fl_empty: got count %0d valid %b ready %b expected 0 0 1", count, out_valid, in_ready); else pass_cnt++;
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk_cnt++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL fl_no_ghost: got count %0d valid %b expected 0 0", count, out_valid); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = W'(64'h11); tick();
    in_data = W'(64'h22); tick();
    in_data = W'(64'h33); rst = 1'b1;
    tick();
    chk_cnt++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mr_state: got count %0d valid %b ready %b expected 0 0 1", count, out_valid, in_ready); else pass_cnt++;
    chk_cnt++; if (out_data !== '0) $display("FAIL mr_data: got %h expected 0", out_data); else pass_cnt++;
    rst = 1'b0; in_data = W'(64'h3);
    tick();
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== W'(64'h3)) $display("FAIL mr_push: got valid %b data %h expected 1 3", out_valid, out_data); else pass_cnt++;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_cnt++; if (count !== 2'd0) $display("FAIL mr_drain: got count %0d expected 0", count); else pass_cnt++;
  endtask

  task automatic test_random();
    bit hold;
    int unsigned errs = 0;
    for (int n = 0; n < 3000; n++) begin
      hold = in_valid && !last_push && !flush && !rst;
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'({$urandom, $urandom});
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
      chk_cnt++; if (out_valid !== (mq.size() != 0)) begin errs++; if (errs < 20) $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, mq.size() != 0); end else pass_cnt++;
      chk_cnt++; if (in_ready !== (mq.size() < 2)) begin errs++; if (errs < 20) $display("FAIL rnd_ready[%0d]: got %b expected %b", n, in_ready, mq.size() < 2); end else pass_cnt++;
      chk_cnt++; if (count !== 2'(mq.size())) begin errs++; if (errs < 20) $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, count, mq.size()); end else pass_cnt++;
      if (mq.size() != 0) begin
        chk_cnt++; if (out_data !== mq[0]) begin errs++; if (errs < 20) $display("FAIL rnd_data[%0d]: got %h expected %h", n, out_data, mq[0]); end else pass_cnt++;
      end else if (mdl_zero) begin
        chk_cnt++; if (out_data !== '0) begin errs++; if (errs < 20) $display("FAIL rnd_zero[%0d]: got %h expected 0", n, out_data); end else pass_cnt++;
      end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    mdl_zero = 1'b1; last_push = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_push_pop();
    test_flush();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
